// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the data memory responder.
package mem_pkg;

  localparam int MEM_N       = 24;
  localparam int MEM_DEPTH   = 256;
  localparam int MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
interface data_memory_responder_if
  import mem_pkg::*;
#(
  parameter int N = MEM_N
);
  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic         ready;
  logic [N-1:0] rdata;
  logic         err;
  logic         busy;

  modport master (output req, we, addr, wdata, input ready, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, output ready, rdata, err, busy);
endinterface

// File: rtl/data_ram.sv
// DEPTH x N word array: synchronous write, asynchronous read, no reset.
module data_ram #(
  parameter int N     = 24,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [N-1:0]             wdata_i,
  output logic [N-1:0]             rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding memory responder: accept, wait LATENCY cycles, pulse ready.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int N       = MEM_N,
  parameter int DEPTH   = MEM_DEPTH,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  data_memory_responder_if.slave  bus
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [3:0]   LAT4     = 4'(LATENCY);
  localparam bit           ZERO_LAT = (LATENCY == 0);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;

  logic         accept;
  logic         wait_done;
  logic         enter_resp;
  logic         cur_we;
  logic [N-1:0] cur_addr;
  logic [N-1:0] cur_wdata;
  logic         cur_err;
  logic         ram_we;
  logic [N-1:0] ram_rdata;

  assign accept     = (state_q == ST_IDLE) && bus.req;
  assign wait_done  = (state_q == ST_WAIT) && (cnt_q <= 4'd1);
  assign enter_resp = (accept && ZERO_LAT) || wait_done;

  // With zero latency the access resolves on the accepting edge, before the
  // capture registers are loaded, so the live bus values are used there.
  assign cur_we    = (state_q == ST_IDLE) ? bus.we    : we_q;
  assign cur_addr  = (state_q == ST_IDLE) ? bus.addr  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? bus.wdata : wdata_q;
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (|(cur_addr >> (AW + 2)));

  // Gating with rst keeps an idle-state accept from writing while held in reset.
  assign ram_we = enter_resp && cur_we && !cur_err && rst;

  data_ram #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (cur_addr[AW+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = LAT4;
          state_d = ZERO_LAT ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (wait_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_we || cur_err) ? '0 : ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready = (state_q == ST_RESP);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised and directed checks of the responder against a word-array model.
module tb_data_memory_responder;
  import mem_pkg::*;

  localparam int N     = 24;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_memory_responder_if #(.N(N)) bus  ();
  data_memory_responder_if #(.N(N)) bus0 ();

  data_memory_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  data_memory_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what each word should hold, and whether it was ever written.
  logic [N-1:0] model [DEPTH];
  bit           known [DEPTH];

  function automatic bit exp_err(input logic [N-1:0] a);
    return (a % 4 != 0) || (int'(a) >= 4 * DEPTH);
  endfunction

  // Drives one transaction on the LATENCY=2 instance and reports what it saw.
  task automatic run_txn(input logic w, input logic [N-1:0] a, input logic [N-1:0] d,
                         output logic [N-1:0] rd, output logic e, output int cyc,
                         output bit busy_ok, output bit one_shot);
    busy_ok  = 1'b1;
    bus.req  = 1'b1;
    bus.we   = w;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk); #1;
    bus.req   = 1'b0;
    bus.we    = 1'($urandom);
    bus.addr  = N'($urandom);
    bus.wdata = N'($urandom);
    cyc = 1;
    while (!bus.ready && cyc < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    rd = bus.rdata;
    e  = bus.err;
    @(posedge clk); #1;
    one_shot = !bus.ready && !bus.busy;
    $display("txn we=%0b addr=%06h wdata=%06h -> rdata=%06h err=%0b ready_cycle=%0d",
             w, a, d, rd, e, cyc);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b exp=0", bus.ready); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    n_checks++; if (bus.rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%06h exp=0", bus.rdata); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [N-1:0] rd; logic e; int cyc; bit bok, os;
    run_txn(1'b1, 24'h000010, 24'hABCDEF, rd, e, cyc, bok, os);
    model[4] = 24'hABCDEF; known[4] = 1'b1;
    n_checks++; if (cyc != LAT + 1) begin n_fail++; $display("FAIL wr_latency got=%0d exp=%0d", cyc, LAT + 1); end
    n_checks++; if (e !== 1'b0 || rd !== '0) begin n_fail++; $display("FAIL wr_resp got err=%0b rdata=%06h exp err=0 rdata=0", e, rd); end
    run_txn(1'b0, 24'h000010, 24'h0, rd, e, cyc, bok, os);
    n_checks++; if (cyc != LAT + 1) begin n_fail++; $display("FAIL rd_latency got=%0d exp=%0d", cyc, LAT + 1); end
    n_checks++; if (e !== 1'b0 || rd !== 24'hABCDEF) begin n_fail++; $display("FAIL rd_data got err=%0b rdata=%06h exp err=0 rdata=abcdef", e, rd); end
    n_checks++; if (!bok || !os) begin n_fail++; $display("FAIL rd_busy_pulse got busy_ok=%0b one_shot=%0b exp 1 1", bok, os); end
  endtask

  task automatic test_misaligned();
    logic [N-1:0] rd; logic e; int cyc; bit bok, os;
    run_txn(1'b1, 24'h000004, 24'h5A5A5A, rd, e, cyc, bok, os);
    model[1] = 24'h5A5A5A; known[1] = 1'b1;
    run_txn(1'b1, 24'h000006, 24'h123456, rd, e, cyc, bok, os);
    n_checks++; if (e !== 1'b1 || rd !== '0) begin n_fail++; $display("FAIL misaligned_wr got err=%0b rdata=%06h exp err=1 rdata=0", e, rd); end
    run_txn(1'b0, 24'h000004, 24'h0, rd, e, cyc, bok, os);
    n_checks++; if (e !== 1'b0 || rd !== model[1]) begin n_fail++; $display("FAIL misaligned_prior got err=%0b rdata=%06h exp err=0 rdata=%06h", e, rd, model[1]); end
  endtask

  task automatic test_out_of_range();
    logic [N-1:0] rd; logic e; int cyc; bit bok, os;
    run_txn(1'b0, 24'h000400, 24'h0, rd, e, cyc, bok, os);
    n_checks++; if (e !== 1'b1 || rd !== '0) begin n_fail++; $display("FAIL oor_read got err=%0b rdata=%06h exp err=1 rdata=0", e, rd); end
    n_checks++; if (cyc != LAT + 1) begin n_fail++; $display("FAIL oor_latency got=%0d exp=%0d", cyc, LAT + 1); end
  endtask

  task automatic test_hold();
    logic [N-1:0] rd; logic e; int cyc; bit bok, os; bit held;
    held = 1'b1;
    repeat (3) begin
      if (bus.err !== 1'b1 || bus.ready !== 1'b0) held = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL hold_err got err=%0b ready=%0b exp err=1 ready=0", bus.err, bus.ready); end
    run_txn(1'b0, 24'h000010, 24'h0, rd, e, cyc, bok, os);
    held = 1'b1;
    repeat (4) begin
      if (bus.rdata !== model[4] || bus.err !== 1'b0 || bus.ready !== 1'b0) held = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL hold_rdata got rdata=%06h err=%0b exp rdata=%06h err=0", bus.rdata, bus.err, model[4]); end
  endtask

  task automatic test_wait_req();
    int k, r1, r2; logic [N-1:0] d1, d2; logic idle_busy;
    r1 = 0; r2 = 0; d1 = '0; d2 = '0; idle_busy = 1'b1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'h000010;
    @(posedge clk); #1;
    bus.req = 1'b0;
    k = 1;
    while (k < 16) begin
      if (k == 2) begin bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'h000004; end
      if (k == LAT + 2) idle_busy = bus.busy;
      if (bus.ready) begin
        if (r1 == 0) begin r1 = k; d1 = bus.rdata; end
        else begin r2 = k; d2 = bus.rdata; bus.req = 1'b0; end
      end
      if (r2 != 0) break;
      @(posedge clk); #1;
      k++;
    end
    bus.req = 1'b0;
    @(posedge clk); #1;
    $display("txn wait_req first_ready=%0d second_ready=%0d", r1, r2);
    n_checks++; if (r1 != LAT + 1 || d1 !== model[4]) begin n_fail++; $display("FAIL waitreq_first got cyc=%0d rdata=%06h exp cyc=%0d rdata=%06h", r1, d1, LAT + 1, model[4]); end
    n_checks++; if (r2 != 2 * LAT + 3 || d2 !== model[1]) begin n_fail++; $display("FAIL waitreq_second got cyc=%0d rdata=%06h exp cyc=%0d rdata=%06h", r2, d2, 2 * LAT + 3, model[1]); end
    n_checks++; if (idle_busy !== 1'b0) begin n_fail++; $display("FAIL waitreq_idle_busy got=%0b exp=0", idle_busy); end
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] rd; logic e; int cyc; bit bok, os; bit pulse;
    run_txn(1'b1, 24'h000020, 24'h222222, rd, e, cyc, bok, os);
    model[8] = 24'h222222; known[8] = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 24'h000020; bus.wdata = 24'h111111;
    @(posedge clk); #1;
    bus.req = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait got busy=%0b exp=1", bus.busy); end
    #2; rst = 1'b0; #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_async got busy=%0b ready=%0b exp 0 0", bus.busy, bus.ready); end
    pulse = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (bus.ready) pulse = 1'b1; end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (bus.ready || bus.busy) pulse = 1'b1; end
    n_checks++; if (pulse) begin n_fail++; $display("FAIL midrst_no_ready got activity=1 exp=0"); end
    run_txn(1'b0, 24'h000020, 24'h0, rd, e, cyc, bok, os);
    n_checks++; if (rd === 24'h111111 || rd !== model[8]) begin n_fail++; $display("FAIL midrst_no_write got rdata=%06h exp=%06h", rd, model[8]); end
  endtask

  task automatic test_random();
    logic [N-1:0] a, d, rd, exp_rd; logic w, e; int cyc, idx; bit bok, os, ee, chk_rd;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       a = N'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        1:       a = N'(4 * DEPTH + $urandom_range(0, 4095));
        default: a = N'($urandom_range(0, 15) * 4);
      endcase
      w  = 1'($urandom);
      d  = N'($urandom);
      ee = exp_err(a);
      idx = ee ? 0 : int'(a) / 4;
      chk_rd = w || ee || known[idx];
      exp_rd = (w || ee) ? '0 : model[idx];
      run_txn(w, a, d, rd, e, cyc, bok, os);
      n_checks++; if (e !== ee) begin n_fail++; $display("FAIL rand_err addr=%06h got=%0b exp=%0b", a, e, ee); end
      n_checks++; if (cyc != LAT + 1) begin n_fail++; $display("FAIL rand_latency addr=%06h got=%0d exp=%0d", a, cyc, LAT + 1); end
      if (chk_rd) begin
        n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata addr=%06h got=%06h exp=%06h", a, rd, exp_rd); end
      end
      n_checks++; if (!bok || !os) begin n_fail++; $display("FAIL rand_busy_pulse addr=%06h got busy_ok=%0b one_shot=%0b exp 1 1", a, bok, os); end
      if (w && !ee) begin model[idx] = d; known[idx] = 1'b1; end
    end
  endtask

  task automatic write0(input logic [N-1:0] a, input logic [N-1:0] d);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = a; bus0.wdata = d;
    @(posedge clk); #1;
    bus0.req = 1'b0;
    @(posedge clk); #1;
    $display("txn lat0 write addr=%06h wdata=%06h", a, d);
  endtask

  task automatic test_back_to_back();
    logic [5:0] rdy, bsy, exp_pat;
    logic [N-1:0] da, db;
    logic [N-1:0] wa, wb;
    wa = N'($urandom); wb = N'($urandom);
    write0(24'h000040, wa);
    write0(24'h000044, wb);
    // Two reads, zero latency: a response every second cycle starting right after accept.
    exp_pat = '0;
    for (int j = 0; j < 2; j++) exp_pat[j * 2] = 1'b1;
    rdy = '0; bsy = '0; da = '0; db = '0;
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 24'h000040;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      rdy[k] = bus0.ready;
      bsy[k] = bus0.busy;
      if (k == 0) begin da = bus0.rdata; bus0.addr = 24'h000044; end
      if (k == 2) begin db = bus0.rdata; bus0.req = 1'b0; end
    end
    $display("txn lat0 back_to_back ready=%06b busy=%06b", rdy, bsy);
    n_checks++; if (rdy !== exp_pat) begin n_fail++; $display("FAIL b2b_ready got=%06b exp=%06b", rdy, exp_pat); end
    n_checks++; if (bsy !== exp_pat) begin n_fail++; $display("FAIL b2b_busy got=%06b exp=%06b", bsy, exp_pat); end
    n_checks++; if (da !== wa || db !== wb) begin n_fail++; $display("FAIL b2b_rdata got=%06h,%06h exp=%06h,%06h", da, db, wa, wb); end
  endtask

  initial begin
    bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin model[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_hold();
    test_wait_req();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
